// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG row-fetch stage: FSM states,
// signed sample rows and the unsigned-to-signed level shift.
package jpeg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAPTURE,
    ST_PRESENT
  } rf_state_t;

  localparam logic [7:0] LEVEL_SHIFT_MASK = 8'h80;

  typedef logic signed [7:0] sample_t;
  typedef sample_t [0:3]     sample_quad_t;
  // Index 0 is the leftmost pixel and lands in the most significant byte.
  typedef sample_t [0:7]     sample_row_t;

  // Big-endian word: byte [31:24] is the lowest-numbered pixel.
  function automatic sample_quad_t level_shift4(input logic [31:0] word);
    sample_quad_t q;
    q[0] = sample_t'(word[31:24] ^ LEVEL_SHIFT_MASK);
    q[1] = sample_t'(word[23:16] ^ LEVEL_SHIFT_MASK);
    q[2] = sample_t'(word[15:8]  ^ LEVEL_SHIFT_MASK);
    q[3] = sample_t'(word[7:0]   ^ LEVEL_SHIFT_MASK);
    return q;
  endfunction

endpackage

// File: rtl/jpeg_row_fetch.sv
// Reads one 8x8 block from the DMA input BRAM, two words per row, and
// presents level-shifted rows to the DCT over a valid/ready handshake.
module jpeg_row_fetch
  import jpeg_pkg::*;
#(
  parameter int BLOCK_ROWS = 8,
  parameter int ADDR_W     = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] bram_addr_o,
  input  logic [31:0]       bram_data_i,
  output logic              row_valid_o,
  input  logic              row_ready_i,
  output logic [63:0]       row_data_o,
  output logic [2:0]        row_idx_o,
  output logic              last_row_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] LAST_ROW = 3'(BLOCK_ROWS - 1);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [2:0]        r_row;
  logic [ADDR_W-1:0] r_base;
  sample_row_t       r_data;
  logic              r_done;
  logic              w_handshake;
  logic [ADDR_W-1:0] w_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_handshake = 1'b0;
    case (r_state)
      ST_IDLE:    if (start_i) w_state_nxt = ST_RD_LO;
      ST_RD_LO:   w_state_nxt = ST_RD_HI;
      ST_RD_HI:   w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_PRESENT;
      ST_PRESENT: begin
        if (row_ready_i) begin
          w_handshake = 1'b1;
          w_state_nxt = (r_row == LAST_ROW) ? ST_IDLE : ST_RD_LO;
        end
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Outside the two read states the address parks on the latched base.
  always_comb begin
    w_addr = r_base;
    case (r_state)
      ST_RD_LO: w_addr = r_base + ADDR_W'({r_row, 1'b0});
      ST_RD_HI: w_addr = r_base + ADDR_W'({r_row, 1'b1});
      default:  w_addr = r_base;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_base  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_base <= base_i;
            r_row  <= '0;
          end
        end
        // BRAM data lags its address by one cycle, so each capture sits
        // one state after the matching read.
        ST_RD_HI:   r_data[0:3] <= level_shift4(bram_data_i);
        ST_CAPTURE: r_data[4:7] <= level_shift4(bram_data_i);
        ST_PRESENT: begin
          if (w_handshake) begin
            if (r_row == LAST_ROW) r_done <= 1'b1;
            else                   r_row  <= r_row + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bram_addr_o = w_addr;
  assign row_valid_o = (r_state == ST_PRESENT);
  assign row_data_o  = r_data;
  assign row_idx_o   = r_row;
  assign last_row_o  = (r_state == ST_PRESENT) && (r_row == LAST_ROW);
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;

endmodule

// File: tb/tb_jpeg_row_fetch.sv
// Self-checking bench for jpeg_row_fetch: BRAM model plus a per-cycle
// timeline/row reference computed from the block memory layout.
module tb_jpeg_row_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  base;
  logic [8:0]  addr;
  logic [31:0] bdata;
  logic        valid;
  logic        ready;
  logic [63:0] data;
  logic [2:0]  idx;
  logic        last;
  logic        busy;
  logic        done;

  logic [31:0] mem [512];
  logic [63:0] seen_rows [8];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) bdata <= mem[addr];

  jpeg_row_fetch #(.BLOCK_ROWS(8), .ADDR_W(9)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_i      (base),
    .bram_addr_o (addr),
    .bram_data_i (bdata),
    .row_valid_o (valid),
    .row_ready_i (ready),
    .row_data_o  (data),
    .row_idx_o   (idx),
    .last_row_o  (last),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row r of the block at base b: pixels 0..3 from word b+2r, 4..7 from
  // word b+2r+1, big-endian bytes, each XOR 0x80; addresses wrap at 512.
  function automatic logic [63:0] exp_row(input logic [8:0] b, input int r);
    logic [63:0] res;
    logic [8:0]  a;
    logic [31:0] w;
    logic [7:0]  px;
    res = '0;
    for (int p = 0; p < 8; p++) begin
      a  = b + 9'(2 * r + p / 4);
      w  = mem[a];
      px = 8'(w >> (24 - 8 * (p % 4)));
      res[63 - 8 * p -: 8] = px ^ 8'h80;
    end
    return res;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  64'(busy),  64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_done"},  64'(done),  64'd0);
  endtask

  // Drives one block starting now and returns in the done_o cycle.
  // k counts cycles since the current row's first read: reads at k=0,1,
  // row visible from k=3 until accepted.
  task automatic run_block(input logic [8:0] b, input int stall_row, input int stall_len,
                           input bit rnd, input int junk_row, input int exp_len);
    int         n;
    int         r;
    int         k;
    int         stalls;
    bit         rdy;
    bit         hs;
    bit         finished;
    logic [8:0] exp_addr;
    start = 1'b1;
    base  = b;
    ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
    tick();
    start    = 1'b0;
    n        = 0;
    r        = 0;
    k        = 0;
    stalls   = 0;
    finished = 1'b0;
    for (int guard = 0; guard < 400 && !finished; guard++) begin
      if (k == 0)      exp_addr = b + 9'(2 * r);
      else if (k == 1) exp_addr = b + 9'(2 * r + 1);
      else             exp_addr = b;
      check("addr",     64'(addr),  64'(exp_addr));
      check("busy",     64'(busy),  64'd1);
      check("done_low", 64'(done),  64'd0);
      check("valid",    64'(valid), 64'(k >= 3));
      if (k >= 3) begin
        check("row_data", data,       exp_row(b, r));
        check("row_idx",  64'(idx),   64'(r));
        check("last_row", 64'(last),  64'(r == 7));
      end
      start = 1'b0;
      if (r == junk_row && k == 1) begin
        start = 1'b1;
        base  = 9'h040;
      end
      if (k >= 3 && r == stall_row && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end else begin
        rdy = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      end
      ready = rdy;
      hs    = (k >= 3) && rdy;
      if (hs) seen_rows[r] = data;
      tick();
      n++;
      if (hs) begin
        if (r == 7) finished = 1'b1;
        else begin
          r++;
          k = 0;
        end
      end else if (k < 3) begin
        k++;
      end
    end
    start = 1'b0;
    if (!finished) begin
      check("block_timeout", 64'd0, 64'd1);
      return;
    end
    check("done_pulse", 64'(done),  64'd1);
    check("busy_end",   64'(busy),  64'd0);
    check("valid_end",  64'(valid), 64'd0);
    if (exp_len >= 0) check("block_len", 64'(n), 64'(exp_len));
  endtask

  initial begin
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    ready = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    repeat (3) tick();
    check_idle_outputs("reset");
    check("reset_addr", 64'(addr), 64'd0);
    check("reset_data", data,      64'd0);
    check("reset_idx",  64'(idx),  64'd0);
    check("reset_last", 64'(last), 64'd0);
    rst = 1'b0;
    tick();

    // Basic incrementing pattern at base 0 with ready tied high.
    for (int k = 0; k < 16; k++) mem[k] = 32'h00010203 + 32'(k) * 32'h04040404;
    run_block(9'h000, -1, 0, 1'b0, -1, 32);
    check("basic_row0", seen_rows[0], 64'h8081828384858687);
    check("basic_row7", seen_rows[7], 64'hB8B9BABBBCBDBEBF);
    tick();
    check_idle_outputs("after_basic");

    // Level-shift extremes.
    for (int k = 0; k < 16; k++) mem[9'h020 + 9'(k)] = 32'h00000000;
    run_block(9'h020, -1, 0, 1'b0, -1, 32);
    check("zero_row3", seen_rows[3], 64'h8080808080808080);
    tick();
    for (int k = 0; k < 16; k++) mem[9'h020 + 9'(k)] = 32'hFFFFFFFF;
    run_block(9'h020, -1, 0, 1'b0, -1, 32);
    check("ff_row5", seen_rows[5], 64'h7F7F7F7F7F7F7F7F);
    tick();

    // Backpressure: five stalled cycles at row 3.
    run_block(9'h060, 3, 5, 1'b0, -1, 37);
    tick();

    // Wrap at the top of the address space, ignored mid-block start,
    // then a start in the done cycle.
    run_block(9'h1F8, -1, 0, 1'b0, 2, 32);
    run_block(9'h010, -1, 0, 1'b0, -1, 32);
    tick();
    check_idle_outputs("after_b2b");

    // Reset while row 2 is presented.
    start = 1'b1;
    base  = 9'h100;
    ready = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 100 && !found; g++) begin
      if (valid && idx == 3'd2) found = 1'b1;
      else tick();
    end
    check("reach_row2", 64'(found), 64'd1);
    rst   = 1'b1;
    ready = 1'b0;
    tick();
    rst = 1'b0;
    check_idle_outputs("midrst");
    check("midrst_addr", 64'(addr), 64'd0);
    check("midrst_data", data,      64'd0);
    check("midrst_idx",  64'(idx),  64'd0);
    for (int g = 0; g < 4; g++) begin
      tick();
      check("midrst_no_done", 64'(done), 64'd0);
    end
    run_block(9'h0A0, -1, 0, 1'b0, -1, 32);
    tick();

    // Randomized contents, bases and ready patterns, random idle gaps.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      run_block(9'($urandom), -1, 0, 1'b1, -1, -1);
      repeat ($urandom_range(2, 0)) tick();
    end
    tick();
    check_idle_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
